// File: rtl/debounce_multi.sv
// N-channel switch conditioner: per-channel synchroniser, stability-count debouncer,
// registered clean level with rise/fall strobes, plus optional long-press and auto-repeat strobes.
module debounce_multi #(
    parameter int NCH           = 4,
    parameter int NDELAY        = 243750,
    parameter int NBITS         = 18,
    parameter int HOLD_CYCLES   = 0,
    parameter int REPEAT_CYCLES = 0,
    parameter int HBITS         = 26
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [NCH-1:0] noisy,
    output logic [NCH-1:0] clean,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic [NCH-1:0] held,
    output logic [NCH-1:0] rpt
);

    localparam logic [NBITS-1:0] DLY       = NBITS'(NDELAY);
    localparam logic [HBITS-1:0] HOLD_LAST = HBITS'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [HBITS-1:0] REP_LAST  = HBITS'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit               REP_EN    = (REPEAT_CYCLES > 0);

    typedef enum logic [1:0] {
        H_IDLE,
        H_HOLD,
        H_RPT
    } hstate_t;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             sync1_q, sync2_q;
        logic             xnew_q, xnew_d;
        logic             clean_q, clean_d;
        logic [NBITS-1:0] count_q, count_d;
        logic             rise_q, fall_q;

        // A change in the synchronised input restarts the window; the count then saturates at DLY.
        always_comb begin
            xnew_d  = xnew_q;
            count_d = count_q;
            clean_d = clean_q;
            if (sync2_q != xnew_q) begin
                xnew_d  = sync2_q;
                count_d = '0;
            end else if (count_q == DLY) begin
                clean_d = xnew_q;
            end else begin
                count_d = count_q + NBITS'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_q <= noisy[i];
                sync2_q <= noisy[i];
                xnew_q  <= noisy[i];
                clean_q <= noisy[i];
                count_q <= '0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                sync1_q <= noisy[i];
                sync2_q <= sync1_q;
                xnew_q  <= xnew_d;
                clean_q <= clean_d;
                count_q <= count_d;
                rise_q  <= clean_d & ~clean_q;
                fall_q  <= ~clean_d & clean_q;
            end
        end

        assign clean[i] = clean_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;

        if (HOLD_CYCLES > 0) begin : g_hold
            hstate_t          hst_q;
            logic [HBITS-1:0] hcnt_q;
            logic             held_q, rpt_q;

            // Tracking only starts on a real rise, so a level loaded high by reset never fires held.
            always_ff @(posedge clk) begin
                if (reset) begin
                    hst_q  <= H_IDLE;
                    hcnt_q <= '0;
                    held_q <= 1'b0;
                    rpt_q  <= 1'b0;
                end else begin
                    held_q <= 1'b0;
                    rpt_q  <= 1'b0;
                    if (!clean_d) begin
                        hst_q  <= H_IDLE;
                        hcnt_q <= '0;
                    end else if (!clean_q) begin
                        hst_q  <= H_HOLD;
                        hcnt_q <= '0;
                    end else begin
                        case (hst_q)
                            H_HOLD: begin
                                if (hcnt_q == HOLD_LAST) begin
                                    held_q <= 1'b1;
                                    hcnt_q <= '0;
                                    hst_q  <= REP_EN ? H_RPT : H_IDLE;
                                end else begin
                                    hcnt_q <= hcnt_q + HBITS'(1);
                                end
                            end
                            H_RPT: begin
                                if (hcnt_q == REP_LAST) begin
                                    rpt_q  <= 1'b1;
                                    hcnt_q <= '0;
                                end else begin
                                    hcnt_q <= hcnt_q + HBITS'(1);
                                end
                            end
                            default: hcnt_q <= '0;
                        endcase
                    end
                end
            end

            assign held[i] = held_q;
            assign rpt[i]  = rpt_q;
        end else begin : g_nohold
            assign held[i] = 1'b0;
            assign rpt[i]  = 1'b0;
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: main build (hold 20, repeat 5) plus hold-off and repeat-off builds.
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] noisy;
    logic [3:0] clean, rise, fall, held, rpt;
    logic [3:0] clean_nh, rise_nh, fall_nh, held_nh, rpt_nh;
    logic [3:0] clean_nr, rise_nr, fall_nr, held_nr, rpt_nr;

    debounce_multi #(.NCH(4), .NDELAY(8), .NBITS(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .HBITS(6)) dut (
        .clk(clk), .reset(reset), .noisy(noisy),
        .clean(clean), .rise(rise), .fall(fall), .held(held), .rpt(rpt)
    );

    debounce_multi #(.NCH(4), .NDELAY(8), .NBITS(4), .HOLD_CYCLES(0), .REPEAT_CYCLES(5), .HBITS(6)) dut_nh (
        .clk(clk), .reset(reset), .noisy(noisy),
        .clean(clean_nh), .rise(rise_nh), .fall(fall_nh), .held(held_nh), .rpt(rpt_nh)
    );

    debounce_multi #(.NCH(4), .NDELAY(8), .NBITS(4), .HOLD_CYCLES(20), .REPEAT_CYCLES(0), .HBITS(6)) dut_nr (
        .clk(clk), .reset(reset), .noisy(noisy),
        .clean(clean_nr), .rise(rise_nr), .fall(fall_nr), .held(held_nr), .rpt(rpt_nr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   n_checks = 0;
    int   n_errors = 0;
    bit   mon_en   = 1'b0;
    int   n_rise[4], n_fall[4], n_held[4], n_rpt[4];
    int   t_rise[4], t_fall[4], t_held[4], t_rpt[4], f_rpt[4];
    int   nr_held[4], nr_theld[4], nr_rpt[4];
    logic [3:0] any_mask;
    logic [3:0] nh_acc = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < 4; c++) begin
                if (rise[c] === 1'b1) begin n_rise[c]++; t_rise[c] = cyc; end
                if (fall[c] === 1'b1) begin n_fall[c]++; t_fall[c] = cyc; end
                if (held[c] === 1'b1) begin n_held[c]++; t_held[c] = cyc; end
                if (rpt[c] === 1'b1) begin
                    if (n_rpt[c] == 0) f_rpt[c] = cyc;
                    n_rpt[c]++;
                    t_rpt[c] = cyc;
                end
                if (held_nr[c] === 1'b1) begin nr_held[c]++; nr_theld[c] = cyc; end
                if (rpt_nr[c] === 1'b1) nr_rpt[c]++;
                if ((rise[c] | fall[c] | held[c] | rpt[c]) !== 1'b0) any_mask[c] = 1'b1;
            end
            nh_acc = nh_acc | held_nh | rpt_nh;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic clr();
        for (int c = 0; c < 4; c++) begin
            n_rise[c] = 0; n_fall[c] = 0; n_held[c] = 0; n_rpt[c] = 0;
            t_rise[c] = -1; t_fall[c] = -1; t_held[c] = -1; t_rpt[c] = -1; f_rpt[c] = -1;
            nr_held[c] = 0; nr_theld[c] = -1; nr_rpt[c] = 0;
        end
        any_mask = '0;
    endtask

    int t0, t1, r;

    initial begin
        reset = 1'b1;
        noisy = 4'b0101;
        clr();
        run(3);
        reset = 1'b0;
        tick();
        chk("rst_clean", 32'(clean), 32'(4'b0101));
        chk("rst_strobes", 32'({rise, fall, held, rpt}), 32'd0);
        mon_en = 1'b1;
        run(30);
        chk("idle_strobes", 32'(any_mask), 32'd0);
        chk("idle_clean", 32'(clean), 32'(4'b0101));

        // Channel 0 low, then a clean press and release
        noisy[0] = 1'b0;
        run(15);
        clr();
        noisy[0] = 1'b1;
        t0 = cyc + 1;
        run(15);
        chk("ch0_rise_cnt", n_rise[0], 1);
        chk("ch0_rise_lat", t_rise[0] - t0, 11);
        chk("ch0_clean_hi", 32'(clean[0]), 32'd1);
        t0 = cyc + 1;
        noisy[0] = 1'b0;
        run(15);
        chk("ch0_fall_cnt", n_fall[0], 1);
        chk("ch0_fall_lat", t_fall[0] - t0, 11);
        chk("ch0_no_held", n_held[0], 0);

        // Channel 1 glitches, then a bounce train settling high
        clr();
        noisy[1] = 1'b1; tick(); noisy[1] = 1'b0;
        run(12);
        noisy[1] = 1'b1; run(6); noisy[1] = 1'b0;
        run(20);
        chk("ch1_glitch_edges", n_rise[1] + n_fall[1], 0);
        chk("ch1_glitch_clean", 32'(clean[1]), 32'd0);
        for (int k = 0; k < 10; k++) begin
            noisy[1] = (k % 2 == 0);
            run(3);
        end
        noisy[1] = 1'b1;
        t0 = cyc + 1;
        run(20);
        chk("ch1_bounce_rise_cnt", n_rise[1], 1);
        chk("ch1_bounce_rise_lat", t_rise[1] - t0, 11);
        chk("ch1_bounce_fall_cnt", n_fall[1], 0);

        // Channel 2 long press with auto-repeat, released so clean falls at R+32
        noisy[2] = 1'b0;
        run(15);
        clr();
        noisy[2] = 1'b1;
        t0 = cyc + 1;
        r  = t0 + 11;
        run_to(r + 20);
        noisy[2] = 1'b0;
        run_to(r + 45);
        chk("ch2_rise_t", t_rise[2], r);
        chk("ch2_held_cnt", n_held[2], 1);
        chk("ch2_held_t", t_held[2] - r, 20);
        chk("ch2_rpt_cnt", n_rpt[2], 2);
        chk("ch2_rpt_first", f_rpt[2] - r, 25);
        chk("ch2_rpt_last", t_rpt[2] - r, 30);
        chk("ch2_fall_t", t_fall[2] - r, 32);
        chk("nr_held_cnt", nr_held[2], 1);
        chk("nr_held_t", nr_theld[2] - r, 20);
        chk("nr_rpt_cnt", nr_rpt[0] + nr_rpt[1] + nr_rpt[2] + nr_rpt[3], 0);

        // All channels rise together
        noisy = 4'b0000;
        run(15);
        clr();
        noisy = 4'b1111;
        t0 = cyc + 1;
        run(15);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("all_rise_cnt%0d", c), n_rise[c], 1);
            chk($sformatf("all_rise_t%0d", c), t_rise[c] - t0, 11);
        end

        // Reset mid-count on channel 3 reloads the raw level without strobes
        noisy = 4'b0000;
        run(15);
        clr();
        noisy = 4'b1000;
        t0 = cyc + 1;
        run_to(t0 + 6);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_clean", 32'(clean), 32'(4'b1000));
        chk("rst_mid_strobes", 32'({rise, fall, held, rpt}), 32'd0);
        run(5);
        chk("rst_mid_no_rise", n_rise[3], 0);
        clr();
        noisy[3] = 1'b0;
        t1 = cyc + 1;
        run(15);
        chk("rst_restart_fall_cnt", n_fall[3], 1);
        chk("rst_restart_fall_lat", t_fall[3] - t1, 11);
        chk("rst_restart_no_rise", n_rise[3], 0);

        chk("nohold_never", 32'(nh_acc), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
